fetch_unit: RTL and testbench

//  Instruction-fetch stage for the 5-stage stall/bypass pipeline, directly upstream of decode_unit.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_skid_buffer.sv | 51 +++++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR      : canonical bubble instruction (addi x0, x0, 0)
//   pc_sel_e       : next_PC_select encodings driven by decode/execute
//   fetch_state_e  : fetch sequencing states
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'b00,
        PC_SEL_BRANCH = 2'b01,
        PC_SEL_JAL    = 2'b10,
        PC_SEL_JALR   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'b00,
        FETCH_RUN   = 2'b01,
        FETCH_DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding buffer for a fetched instruction and its PC.
// Catches a memory response that arrives while decode is stalled.
//   clock, reset       : single clock, synchronous active-high reset
//   clear              : empty the buffer (highest priority after reset)
//   load               : capture load_data/load_pc, buffer becomes full
//   unload             : buffer becomes empty (contents remain readable)
//   load_data, load_pc : entry to capture
//   full               : buffer holds a valid entry
//   data, pc           : stored entry
module fetch_skid_buffer
#(
    parameter int ADDRESS_BITS = 20,
    parameter int DATA_WIDTH   = 32
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    unload,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic [ADDRESS_BITS-1:0] load_pc,
    output logic                    full,
    output logic [DATA_WIDTH-1:0]   data,
    output logic [ADDRESS_BITS-1:0] pc
);

    logic                    full_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDRESS_BITS-1:0] pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            full_q <= 1'b1;
            data_q <= load_data;
            pc_q   <= load_pc;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign pc   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one request per cycle to
// a synchronous instruction memory (response exactly one cycle after accept),
// applies redirects, and presents a registered instruction/PC/valid to decode.
//   clock, reset                 : single clock, synchronous active-high reset
//   stall                        : hold decode-side outputs
//   next_PC_select               : 00 seq, 01 branch, 10 JAL, 11 JALR
//   branch_target/JAL_target/JALR_target : redirect targets
//   imem_req/imem_addr/imem_ready : request handshake
//   imem_valid/imem_rdata        : response
//   instruction_decode/PC_decode/valid_decode : to decode_unit
//   report                       : trace enable (consumed by simulation-only tracing)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      CORE         = 0,
    parameter int                      ADDRESS_BITS = 20,
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              next_PC_select,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_valid,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic [DATA_WIDTH-1:0]   instruction_decode,
    output logic [ADDRESS_BITS-1:0] PC_decode,
    output logic                    valid_decode,
    input  logic                    report
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    fetch_state_e state_q, state_d;

    logic [ADDRESS_BITS-1:0] pc_q;
    logic [ADDRESS_BITS-1:0] req_pc_q;
    logic                    outstanding_q;
    logic                    drop_q;

    logic [DATA_WIDTH-1:0]   instr_q;
    logic [ADDRESS_BITS-1:0] pc_dec_q;
    logic                    valid_q;

    pc_sel_e                 pc_sel;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] target;
    logic                    fire;
    logic                    resp;

    logic                    skid_full;
    logic                    skid_load;
    logic                    skid_unload;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [ADDRESS_BITS-1:0] skid_pc;

    // Tracing is done outside the synthesizable RTL; the trace enable and core id
    // are kept on the interface for drop-in compatibility.
    logic unused_trace;
    assign unused_trace = report ^ CORE[0];

    assign pc_sel   = pc_sel_e'(next_PC_select);
    assign redirect = (pc_sel != PC_SEL_SEQ);

    always_comb begin
        target = '0;
        unique case (pc_sel)
            PC_SEL_BRANCH: target = branch_target;
            PC_SEL_JAL:    target = JAL_target;
            PC_SEL_JALR:   target = JALR_target;
            default:       target = pc_q;
        endcase
    end

    assign fire = imem_req & imem_ready;
    // Only a response to a request this unit still wants is consumed.
    assign resp = imem_valid & outstanding_q & ~drop_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH_BOOT;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_BOOT:  state_d = FETCH_RUN;
            FETCH_RUN:   if (redirect && outstanding_q) state_d = FETCH_DRAIN;
            FETCH_DRAIN: state_d = FETCH_RUN;
            default:     state_d = FETCH_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req = 1'b0;
        if (state_q == FETCH_RUN && !stall && !skid_full && !redirect)
            imem_req = 1'b1;
    end

    assign imem_addr = pc_q;

    // ---------------- PC and request tracking ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            if (redirect)
                pc_q <= {target[ADDRESS_BITS-1:2], 2'b00};
            else if (fire)
                pc_q <= pc_q + ADDRESS_BITS'(4);

            if (fire)
                req_pc_q <= pc_q;

            if (fire)
                outstanding_q <= 1'b1;
            else if (imem_valid)
                outstanding_q <= 1'b0;

            // The in-flight response coincides with the redirect cycle and is
            // discarded there; drop marks the DRAIN cycle so nothing stray is taken.
            drop_q <= redirect & outstanding_q;
        end
    end

    // ---------------- Skid buffer ----------------
    assign skid_load   = resp & stall & ~redirect;
    assign skid_unload = skid_full & ~stall & ~redirect;

    fetch_skid_buffer #(
        .ADDRESS_BITS(ADDRESS_BITS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .clear    (redirect),
        .load     (skid_load),
        .unload   (skid_unload),
        .load_data(imem_rdata),
        .load_pc  (req_pc_q),
        .full     (skid_full),
        .data     (skid_data),
        .pc       (skid_pc)
    );

    // ---------------- Decode output registers ----------------
    // Bubbles replace the instruction with NOP and drop valid; PC_decode keeps
    // its last value since it is meaningless while valid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q  <= NOP;
            pc_dec_q <= '0;
            valid_q  <= 1'b0;
        end else if (redirect) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (stall) begin
            // hold; any arriving response goes to the skid buffer
        end else if (skid_full) begin
            instr_q  <= skid_data;
            pc_dec_q <= skid_pc;
            valid_q  <= 1'b1;
        end else if (resp) begin
            instr_q  <= imem_rdata;
            pc_dec_q <= req_pc_q;
            valid_q  <= 1'b1;
        end else begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end
    end

    assign instruction_decode = instr_q;
    assign PC_decode          = pc_dec_q;
    assign valid_decode       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int AB = 20;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic [1:0]    next_PC_select = 2'b00;
    logic [AB-1:0] branch_target = 20'h3333C;
    logic [AB-1:0] JAL_target    = 20'h5555C;
    logic [AB-1:0] JALR_target   = 20'h7777C;
    logic          imem_req;
    logic [AB-1:0] imem_addr;
    logic          imem_ready = 1'b1;
    logic          imem_valid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instruction_decode;
    logic [AB-1:0] PC_decode;
    logic          valid_decode;
    logic          report = 1'b0;

    logic          mem_valid_q = 1'b0;
    logic [DW-1:0] mem_rdata_q = '0;
    logic          force_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_unit #(
        .CORE        (0),
        .ADDRESS_BITS(AB),
        .DATA_WIDTH  (DW),
        .RESET_PC    (20'h00000)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .next_PC_select    (next_PC_select),
        .branch_target     (branch_target),
        .JAL_target        (JAL_target),
        .JALR_target       (JALR_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .instruction_decode(instruction_decode),
        .PC_decode         (PC_decode),
        .valid_decode      (valid_decode),
        .report            (report)
    );

    function automatic logic [DW-1:0] tag(input logic [AB-1:0] a);
        return {12'hABC, a};
    endfunction

    // Synchronous memory: response exactly one cycle after an accepted request.
    always @(posedge clock) begin
        mem_valid_q <= imem_req & imem_ready;
        mem_rdata_q <= tag(imem_addr);
    end
    assign imem_valid = mem_valid_q | force_valid;
    assign imem_rdata = force_valid ? 32'hDEAD_BEEF : mem_rdata_q;

    typedef struct {
        logic          stall;
        logic [1:0]    sel;
        logic [AB-1:0] target;
        logic          ready;
        logic          exp_req;
        logic [AB-1:0] exp_addr;
        logic          exp_valid;
        logic [AB-1:0] exp_pc;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic s, input logic [1:0] sel, input logic [AB-1:0] t,
                                input logic rdy, input logic er, input logic [AB-1:0] ea,
                                input logic ev, input logic [AB-1:0] ep);
        vec_t v;
        v.stall = s; v.sel = sel; v.target = t; v.ready = rdy;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_decode(input string name, input logic ev, input logic [AB-1:0] ep);
        check({name, ".valid"}, 32'(valid_decode), 32'(ev));
        check({name, ".instr"}, instruction_decode, ev ? tag(ep) : NOP);
        if (ev) check({name, ".pc"}, 32'(PC_decode), 32'(ep));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // stall, sel, target, ready | req, addr, valid, pc
        // Boot and streaming from RESET_PC
        vecs[0]  = mk(0, 2'b00, 20'h0,     1, 0, 20'h00000, 0, 20'h0);
        vecs[1]  = mk(0, 2'b00, 20'h0,     1, 1, 20'h00000, 0, 20'h0);
        vecs[2]  = mk(0, 2'b00, 20'h0,     1, 1, 20'h00004, 1, 20'h00000);
        vecs[3]  = mk(0, 2'b00, 20'h0,     1, 1, 20'h00008, 1, 20'h00004);
        vecs[4]  = mk(0, 2'b00, 20'h0,     1, 1, 20'h0000C, 1, 20'h00008);
        vecs[5]  = mk(0, 2'b00, 20'h0,     1, 1, 20'h00010, 1, 20'h0000C);
        // Stall 3 cycles: 0x10 response goes to skid, decode holds 0x0C
        vecs[6]  = mk(1, 2'b00, 20'h0,     1, 0, 20'h00014, 1, 20'h0000C);
        vecs[7]  = mk(1, 2'b00, 20'h0,     1, 0, 20'h00014, 1, 20'h0000C);
        vecs[8]  = mk(1, 2'b00, 20'h0,     1, 0, 20'h00014, 1, 20'h0000C);
        vecs[9]  = mk(0, 2'b00, 20'h0,     1, 0, 20'h00014, 1, 20'h00010);
        vecs[10] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00014, 0, 20'h0);
        vecs[11] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00018, 1, 20'h00014);
        // JAL back to 0 while 0x18 in flight
        vecs[12] = mk(0, 2'b10, 20'h00000, 1, 0, 20'h0001C, 0, 20'h0);
        vecs[13] = mk(0, 2'b00, 20'h0,     1, 0, 20'h00000, 0, 20'h0);
        vecs[14] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00000, 0, 20'h0);
        vecs[15] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00004, 1, 20'h00000);
        vecs[16] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00008, 1, 20'h00004);
        // Branch to 0x40 while 0x08 in flight: 0x08 dropped
        vecs[17] = mk(0, 2'b01, 20'h00040, 1, 0, 20'h0000C, 0, 20'h0);
        vecs[18] = mk(0, 2'b00, 20'h0,     1, 0, 20'h00040, 0, 20'h0);
        vecs[19] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00040, 0, 20'h0);
        vecs[20] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00044, 1, 20'h00040);
        // Fill skid under stall, then JALR 0x27 during stall clears it
        vecs[21] = mk(1, 2'b00, 20'h0,     1, 0, 20'h00048, 1, 20'h00040);
        vecs[22] = mk(1, 2'b11, 20'h00027, 1, 0, 20'h00048, 0, 20'h0);
        vecs[23] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00024, 0, 20'h0);
        vecs[24] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00028, 1, 20'h00024);
        // Jump to top of address space, hold with ready=0, then wrap
        vecs[25] = mk(0, 2'b10, 20'hFFFFC, 1, 0, 20'h0002C, 0, 20'h0);
        vecs[26] = mk(0, 2'b00, 20'h0,     1, 0, 20'hFFFFC, 0, 20'h0);
        vecs[27] = mk(0, 2'b00, 20'h0,     0, 1, 20'hFFFFC, 0, 20'h0);
        vecs[28] = mk(0, 2'b00, 20'h0,     0, 1, 20'hFFFFC, 0, 20'h0);
        vecs[29] = mk(0, 2'b00, 20'h0,     1, 1, 20'hFFFFC, 0, 20'h0);
        vecs[30] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00000, 1, 20'hFFFFC);
        vecs[31] = mk(0, 2'b00, 20'h0,     1, 1, 20'h00004, 1, 20'h00000);

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst.valid", 32'(valid_decode), 32'd0);
        check("rst.instr", instruction_decode, NOP);
        check("rst.pc", 32'(PC_decode), 32'd0);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.addr", 32'(imem_addr), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            stall          = vecs[i].stall;
            next_PC_select = vecs[i].sel;
            imem_ready     = vecs[i].ready;
            branch_target  = (vecs[i].sel == 2'b01) ? vecs[i].target : 20'h3333C;
            JAL_target     = (vecs[i].sel == 2'b10) ? vecs[i].target : 20'h5555C;
            JALR_target    = (vecs[i].sel == 2'b11) ? vecs[i].target : 20'h7777C;
            #1;
            check($sformatf("v%0d.req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            step();
            check_decode($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Reset while the 0x04 response is outstanding
        stall = 1'b0;
        next_PC_select = 2'b00;
        imem_ready = 1'b1;
        reset = 1'b1;
        step();
        check("rst2.valid", 32'(valid_decode), 32'd0);
        check("rst2.instr", instruction_decode, NOP);
        check("rst2.pc", 32'(PC_decode), 32'd0);
        check("rst2.req", 32'(imem_req), 32'd0);
        check("rst2.addr", 32'(imem_addr), 32'd0);
        // A response right after reset must be ignored
        reset = 1'b0;
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        check("post_rst.valid", 32'(valid_decode), 32'd0);
        check("post_rst.instr", instruction_decode, NOP);
        check("post_rst.pc", 32'(PC_decode), 32'd0);
        #1;
        check("post_rst.req", 32'(imem_req), 32'd1);
        check("post_rst.addr", 32'(imem_addr), 32'd0);
        step();
        check_decode("post_rst.bubble", 1'b0, 20'h0);
        step();
        check_decode("post_rst.first", 1'b1, 20'h00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
